ls90_sequencer: RTL and testbench
=================================

Name: ls90_sequencer

Overview:
- Synchronous controller that sequences one decimal-counter chip (divide-by-two plus divide-by-five sections, async active-low clocks, async R0/R9 pins, BCD outputs) from the system clock domain.
- Accepts CLEAR, SET9 and COUNT-n commands over a valid/ready handshake.
- Generates correctly timed cp1_n/cp2_n pulses, chaining qa's falling edge into cp2_n for a BCD cascade. Drives the reset-to-0 and set-to-9 pin pairs.
- Samples qa..qd after settling and reports the resulting digit.
- Sits between bench/UI logic and the chip model on the board.

Parameters:
- PULSE_W, 2: clock cycles each cp*_n / R pin pulse stays asserted (min 1).
- SETTLE, 3: clock cycles waited after a pulse deasserts before sampling q* (min 1; must cover the chip's output DELAY).
- CNT_W, 8: width of the COUNT pulse-count field.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller idle; command accepted on the edge where cmd_valid & cmd_ready.
- cmd_op  in  2  00 NOP, 01 CLEAR, 10 SET9, 11 COUNT.
- cmd_n  in  CNT_W  number of input pulses for COUNT; ignored otherwise.
- cp1_n  out  1  to chip divide-by-two clock; idle high.
- cp2_n  out  1  to chip divide-by-five clock; idle high.
- r0_1, r0_2  out  1 each  reset-to-0 pin pair; idle low.
- r9_1, r9_2  out  1 each  set-to-9 pin pair; idle low.
- qa, qb, qc, qd  in  1 each  chip outputs (asynchronous; double-flop synchronised internally).
- bcd  out  4  last sampled digit {qd,qc,qb,qa}.
- bcd_valid  out  1  bcd reflects the chip since the last reset.
- done  out  1  one-cycle pulse on command completion.

Behaviour:
- Reset (clk edge with rst=1):
  - State IDLE; cmd_ready=1.
  - cp1_n=cp2_n=1; all r* pins=0.
  - bcd=0, bcd_valid=0, done=0; internal counters cleared.
  - rst mid-command aborts immediately; pins return to idle values on that edge. The chip state is then undefined, so bcd_valid stays 0 until the next completed command.
- cmd_valid during rst is ignored.
- FSM states: IDLE, RPULSE, RSETTLE, CP1_LO, CP1_WAIT, CP2_LO, CP2_WAIT, SAMPLE, DONE.
- IDLE: cmd_ready=1. On accept, cmd_ready drops the next cycle and the operation is latched:
  - NOP → SAMPLE.
  - CLEAR → RPULSE with r0_1=r0_2=1.
  - SET9 → RPULSE with r9_1=r9_2=1.
  - COUNT with cmd_n=0 → SAMPLE.
  - COUNT with cmd_n>0 → CP1_LO, remaining=cmd_n.
- RPULSE: selected pin pair held high exactly PULSE_W cycles → RSETTLE (pins low), SETTLE cycles → SAMPLE.
- CP1_LO: cp1_n=0 for PULSE_W cycles. Synchronised qa is captured as qa_prev on entry.
- CP1_WAIT: cp1_n=1 for SETTLE cycles. At the end:
  - if qa_prev=1 and qa=0 (falling edge, BCD carry into ÷5) → CP2_LO;
  - otherwise decrement remaining; → CP1_LO if remaining≠0, else SAMPLE.
- CP2_LO: cp2_n=0 for PULSE_W cycles → CP2_WAIT.
- CP2_WAIT: SETTLE cycles, then decrement remaining; → CP1_LO if remaining≠0, else SAMPLE.
- Cycle cost per COUNT pulse: PULSE_W+SETTLE, plus PULSE_W+SETTLE again when a carry occurs.
- SAMPLE (1 cycle): bcd ← synchronised {qd,qc,qb,qa}; bcd_valid ← 1 → DONE.
- DONE (1 cycle): done=1, cmd_ready=1. A command may be accepted in this cycle (back-to-back); otherwise → IDLE.
- Never drives r0 and r9 pairs simultaneously.
- Never drives cp*_n low while any r* pin is high.
- cp1_n and cp2_n are never low in the same cycle.
- remaining is CNT_W bits; cmd_n=2^CNT_W−1 is legal and produces exactly that many cp1_n pulses.
- Output value wraps 9→0 naturally via the chip; the controller performs no modulo arithmetic on bcd.

Optional Feature:
- Macro LS90_MODEL_CHECK_EN.
- Defined: the controller keeps a shadow digit.
  - CLEAR sets it to 0; SET9 sets it to 9; COUNT adds cmd_n mod 10 (incremental, +1 per cp1 pulse, 9→0).
  - In SAMPLE, a mismatch between bcd and the shadow sets a sticky output mismatch (1 bit, reset 0).
  - Shadow is invalid after reset until the first CLEAR or SET9; no check while invalid.
- Undefined: no shadow logic and no mismatch port.

Test Plan:
- rst, then CLEAR → r0 pair high exactly 2 cycles, done after 2+3+1+1 cycles from accept; bcd=0, bcd_valid=1.
- CLEAR, then COUNT n=3 → 3 cp1_n pulses and 1 cp2_n pulse (after the 2nd cp1); bcd=3, no cp*_n overlap.
- SET9, then COUNT n=1 → bcd=9 after SET9; after COUNT one cp1 pulse and one cp2 pulse; bcd=0.
- CLEAR, COUNT n=25 → bcd=5; cp2_n pulse count=12. COUNT n=0 → no pulses, bcd=5, done 2 cycles after accept.
- rst asserted mid-COUNT (during CP2_LO) → next edge cp2_n=1, cmd_ready=1, bcd_valid=0; CLEAR then recovers bcd=0.
- With LS90_MODEL_CHECK_EN: force qb stuck-at-0, CLEAR, COUNT n=2 → mismatch=1 and held until rst.

Source files
------------

// File: rtl/ls90_sequencer.sv
// ls90_sequencer: drives one decade-counter chip (clock pulses, R0/R9 pins) and samples its BCD digit.
// Defining LS90_MODEL_CHECK_EN adds a shadow digit and a sticky mismatch output.
module ls90_sequencer #(
  parameter int PULSE_W = 2,
  parameter int SETTLE  = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_n,
  output logic             cp1_n,
  output logic             cp2_n,
  output logic             r0_1,
  output logic             r0_2,
  output logic             r9_1,
  output logic             r9_2,
  input  logic             qa,
  input  logic             qb,
  input  logic             qc,
  input  logic             qd,
  output logic [3:0]       bcd,
  output logic             bcd_valid,
  output logic             done
`ifdef LS90_MODEL_CHECK_EN
  , output logic           mismatch
`endif
);
  typedef enum logic [3:0] {IDLE, RPULSE, RSETTLE, CP1_LO, CP1_WAIT, CP2_LO, CP2_WAIT, SAMPLE, DONE} state_t;
  state_t state, state_n;
  logic [15:0] tmr, tmr_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic set9, set9_n, qa_prev, qa_prev_n;
  logic [3:0] q_s1, q_s2;
  logic accept, pw_end, st_end, cp1_entry;
  assign cmd_ready = state == IDLE || state == DONE;
  assign done      = state == DONE;
  assign accept    = cmd_valid & cmd_ready;
  assign pw_end    = tmr == 16'(PULSE_W - 1);
  assign st_end    = tmr == 16'(SETTLE - 1);
  assign cp1_entry = state_n == CP1_LO && state != CP1_LO;
  always_comb begin
    state_n   = state;
    tmr_n     = tmr + 16'd1;
    rem_n     = rem;
    set9_n    = set9;
    qa_prev_n = qa_prev;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (accept) begin
          tmr_n = '0;
          case (cmd_op)
            2'b01, 2'b10: begin
              state_n = RPULSE;
              set9_n  = cmd_op[1];
            end
            2'b11: begin
              state_n = (cmd_n != '0) ? CP1_LO : SAMPLE;
              rem_n   = cmd_n;
            end
            default: state_n = SAMPLE;
          endcase
        end
      end
      RPULSE:   if (pw_end) begin state_n = RSETTLE;  tmr_n = '0; end
      RSETTLE:  if (st_end) begin state_n = SAMPLE;   tmr_n = '0; end
      CP1_LO:   if (pw_end) begin state_n = CP1_WAIT; tmr_n = '0; end
      CP2_LO:   if (pw_end) begin state_n = CP2_WAIT; tmr_n = '0; end
      CP1_WAIT: if (st_end) begin
        tmr_n = '0;
        if (qa_prev && !q_s2[0]) state_n = CP2_LO;
        else begin
          rem_n   = rem - CNT_W'(1);
          state_n = (rem_n != '0) ? CP1_LO : SAMPLE;
        end
      end
      CP2_WAIT: if (st_end) begin
        tmr_n   = '0;
        rem_n   = rem - CNT_W'(1);
        state_n = (rem_n != '0) ? CP1_LO : SAMPLE;
      end
      SAMPLE:   state_n = DONE;
      default:  state_n = IDLE;
    endcase
    // qa before this pulse takes effect; a 1->0 change afterwards is the carry into the /5 section
    if (cp1_entry) qa_prev_n = q_s2[0];
  end
  // pins are registered from the next state so they switch cleanly and track the state exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tmr       <= '0;
      rem       <= '0;
      set9      <= 1'b0;
      qa_prev   <= 1'b0;
      q_s1      <= '0;
      q_s2      <= '0;
      cp1_n     <= 1'b1;
      cp2_n     <= 1'b1;
      r0_1      <= 1'b0;
      r0_2      <= 1'b0;
      r9_1      <= 1'b0;
      r9_2      <= 1'b0;
      bcd       <= '0;
      bcd_valid <= 1'b0;
    end else begin
      state   <= state_n;
      tmr     <= tmr_n;
      rem     <= rem_n;
      set9    <= set9_n;
      qa_prev <= qa_prev_n;
      q_s1    <= {qd, qc, qb, qa};
      q_s2    <= q_s1;
      cp1_n   <= state_n != CP1_LO;
      cp2_n   <= state_n != CP2_LO;
      r0_1    <= state_n == RPULSE && !set9_n;
      r0_2    <= state_n == RPULSE && !set9_n;
      r9_1    <= state_n == RPULSE && set9_n;
      r9_2    <= state_n == RPULSE && set9_n;
      if (state == SAMPLE) begin
        bcd       <= q_s2;
        bcd_valid <= 1'b1;
      end
    end
  end
`ifdef LS90_MODEL_CHECK_EN
  logic [3:0] shadow;
  logic shadow_ok;
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      shadow_ok <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      if (accept && cmd_op == 2'b01) begin
        shadow    <= 4'd0;
        shadow_ok <= 1'b1;
      end else if (accept && cmd_op == 2'b10) begin
        shadow    <= 4'd9;
        shadow_ok <= 1'b1;
      end else if (cp1_entry) shadow <= (shadow == 4'd9) ? 4'd0 : shadow + 4'd1;
      if (state == SAMPLE && shadow_ok && q_s2 != shadow) mismatch <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_ls90_sequencer.sv
// tb_ls90_sequencer: directed vectors against a behavioural decade-counter chip model.
module tb_ls90_sequencer;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [7:0] cmd_n = '0;
  logic cmd_ready, cp1_n, cp2_n, r0_1, r0_2, r9_1, r9_2, done, bcd_valid;
  logic [3:0] bcd;
  logic chip_qa = 1'b0, stuck_qb = 1'b0;
  logic [2:0] d5 = '0;
  logic r0, r9;
  int vectors = 0, miscompares = 0;
  int cp1_cnt = 0, cp2_cnt = 0, cp1_at_cp2 = 0, viol = 0;
  int r0_run = 0, r0_w = 0, r9_run = 0, r9_w = 0, r9_cyc = 0;
  int lat, b1, b2, b9;
`ifdef LS90_MODEL_CHECK_EN
  logic mismatch;
`endif
  always #5 clk = ~clk;
  ls90_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_n(cmd_n),
    .cp1_n(cp1_n), .cp2_n(cp2_n), .r0_1(r0_1), .r0_2(r0_2), .r9_1(r9_1), .r9_2(r9_2),
    .qa(chip_qa), .qb(d5[0] & ~stuck_qb), .qc(d5[1]), .qd(d5[2]),
    .bcd(bcd), .bcd_valid(bcd_valid), .done(done)
`ifdef LS90_MODEL_CHECK_EN
    , .mismatch(mismatch)
`endif
  );
  assign r0 = r0_1 & r0_2;
  assign r9 = r9_1 & r9_2;
  // chip: qa toggles on cp1_n fall, /5 section {qd,qc,qb} counts 0..4 on cp2_n fall
  always @(negedge cp1_n or posedge r0 or posedge r9)
    if (r0) chip_qa <= 1'b0;
    else if (r9) chip_qa <= 1'b1;
    else chip_qa <= ~chip_qa;
  always @(negedge cp2_n or posedge r0 or posedge r9)
    if (r0) d5 <= 3'd0;
    else if (r9) d5 <= 3'd4;
    else d5 <= (d5 == 3'd4) ? 3'd0 : d5 + 3'd1;
  always @(negedge cp1_n) cp1_cnt++;
  always @(negedge cp2_n) begin
    cp2_cnt++;
    cp1_at_cp2 = cp1_cnt;
  end
  always @(negedge clk) begin
    if (!cp1_n && !cp2_n) viol++;
    if ((r0_1 | r0_2) && (r9_1 | r9_2)) viol++;
    if ((!cp1_n || !cp2_n) && (r0_1 | r0_2 | r9_1 | r9_2)) viol++;
    if (r0) r0_run++;
    else begin
      if (r0_run != 0) r0_w = r0_run;
      r0_run = 0;
    end
    if (r9) begin
      r9_run++;
      r9_cyc++;
    end else begin
      if (r9_run != 0) r9_w = r9_run;
      r9_run = 0;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [1:0] op, input int n);
    @(negedge clk);
    cmd_op = op;
    cmd_n = n[7:0];
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cmd_op = 2'b00;
  endtask
  task automatic wait_done(output int l);
    l = 0;
    for (int i = 1; i < 5000; i++) begin
      @(negedge clk);
      if (done) begin
        l = i;
        break;
      end
    end
    check("done_seen", done, 1);
    @(negedge clk);
  endtask
  task automatic send(input logic [1:0] op, input int n, output int l);
    issue(op, n);
    wait_done(l);
  endtask
  initial begin
    cmd_valid = 1'b1;
    cmd_op = 2'b01;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_cp", {cp1_n, cp2_n}, 2'b11);
    check("rst_rpins", {r0_1, r0_2, r9_1, r9_2}, 0);
    check("rst_bcd", bcd, 0);
    check("rst_valid", bcd_valid, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    @(negedge clk);
    check("no_cmd_from_rst", {r0_1, cmd_ready}, 2'b01);
    send(2'b01, 0, lat);
    check("clear_lat", lat, 7);
    check("clear_r0_w", r0_w, 2);
    check("clear_no_r9", r9_cyc, 0);
    check("clear_bcd", bcd, 0);
    check("clear_valid", bcd_valid, 1);
`ifdef LS90_MODEL_CHECK_EN
    check("clean_mismatch", mismatch, 0);
`endif
    b1 = cp1_cnt; b2 = cp2_cnt;
    send(2'b11, 3, lat);
    check("c3_cp1", cp1_cnt - b1, 3);
    check("c3_cp2", cp2_cnt - b2, 1);
    check("c3_carry_after", cp1_at_cp2 - b1, 2);
    check("c3_lat", lat, 22);
    check("c3_bcd", bcd, 3);
    send(2'b10, 0, lat);
    check("set9_r9_w", r9_w, 2);
    check("set9_bcd", bcd, 9);
    b1 = cp1_cnt; b2 = cp2_cnt;
    send(2'b11, 1, lat);
    check("c1_cp1", cp1_cnt - b1, 1);
    check("c1_cp2", cp2_cnt - b2, 1);
    check("c1_bcd_wrap", bcd, 0);
    send(2'b01, 0, lat);
    b1 = cp1_cnt; b2 = cp2_cnt;
    send(2'b11, 25, lat);
    check("c25_cp1", cp1_cnt - b1, 25);
    check("c25_cp2", cp2_cnt - b2, 12);
    check("c25_bcd", bcd, 5);
    b1 = cp1_cnt; b2 = cp2_cnt;
    send(2'b11, 0, lat);
    check("c0_lat", lat, 2);
    check("c0_pulses", (cp1_cnt - b1) + (cp2_cnt - b2), 0);
    check("c0_bcd", bcd, 5);
    send(2'b00, 0, lat);
    check("nop_lat", lat, 2);
    send(2'b01, 0, lat);
    b1 = cp1_cnt; b2 = cp2_cnt;
    send(2'b11, 255, lat);
    check("c255_cp1", cp1_cnt - b1, 255);
    check("c255_cp2", cp2_cnt - b2, 127);
    check("c255_bcd", bcd, 5);
    send(2'b01, 0, lat);
    issue(2'b11, 3);
    for (int i = 0; i < 200 && cp2_n; i++) @(negedge clk);
    check("mid_in_cp2", cp2_n, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_cp2", cp2_n, 1);
    check("abort_ready", cmd_ready, 1);
    check("abort_valid", bcd_valid, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    send(2'b01, 0, lat);
    check("recover_bcd", bcd, 0);
    check("recover_valid", bcd_valid, 1);
`ifdef LS90_MODEL_CHECK_EN
    stuck_qb = 1'b1;
    send(2'b01, 0, lat);
    send(2'b11, 2, lat);
    check("stuck_bcd", bcd, 0);
    check("stuck_mismatch", mismatch, 1);
    stuck_qb = 1'b0;
    send(2'b01, 0, lat);
    check("mismatch_sticky", mismatch, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mismatch_rst", mismatch, 0);
    rst = 1'b0;
`endif
    check("pin_rules", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
